// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer
// Cuts the free-running NCO sample stream into N-point frames for the FFT
// sink (valid/sop/eop with ready backpressure), then watches the FFT source
// for the matching output frame and counts completed frames. Overflow and
// output framing problems are latched into sticky error flags.
module fft_frame_sequencer #(
    parameter int DATA_W       = 14,
    parameter int FFT_LEN_LOG2 = 10,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              sink_ready,
    output logic              sink_valid,
    output logic              sink_sop,
    output logic              sink_eop,
    output logic [DATA_W-1:0] sink_real,
    output logic [DATA_W-1:0] sink_imag,
    output logic              sink_inverse,
    input  logic              source_valid,
    input  logic              source_sop,
    input  logic              source_eop,
    output logic              source_ready,
    output logic              busy,
    output logic              frame_done,
    output logic [CNT_W-1:0]  frame_count,
    output logic              err_overflow,
    output logic              err_frame
);

    // One spare bit on the output beat counter so over-long frames saturate
    // instead of aliasing back onto a legal length.
    localparam int BEAT_W = FFT_LEN_LOG2 + 1;
    localparam int N      = 1 << FFT_LEN_LOG2;
    localparam logic [BEAT_W-1:0]       LAST_BEAT = BEAT_W'(N - 1);
    localparam logic [BEAT_W-1:0]       BEAT_MAX  = {BEAT_W{1'b1}};
    localparam logic [FFT_LEN_LOG2-1:0] LAST_IDX  = {FFT_LEN_LOG2{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic [FFT_LEN_LOG2-1:0] idx_reg;
    logic                    sink_valid_reg;
    logic                    sink_sop_reg;
    logic                    sink_eop_reg;
    logic [DATA_W-1:0]       sink_real_reg;
    logic [BEAT_W-1:0]       beat_cnt_reg, beat_cnt_next;
    logic                    in_frame_reg, in_frame_next;
    logic                    frame_done_reg;
    logic [CNT_W-1:0]        frame_count_reg;
    logic                    err_overflow_reg;
    logic                    err_frame_reg;

    logic                    xfer;
    logic                    eop_pending;
    logic                    load;
    logic                    drop;
    logic                    src_beat;
    logic                    frame_end;
    logic                    frame_err_evt;
    logic [BEAT_W-1:0]       cur_beat;

    // Sink-side handshake qualifiers. Once the eop sample sits in the output
    // register nothing else is loaded, so the next frame always begins with a
    // clean sop after the source side has drained.
    assign xfer        = sink_valid_reg & sink_ready;
    assign eop_pending = sink_valid_reg & sink_eop_reg;
    assign load        = (state_reg == FEED) & in_valid
                         & (~sink_valid_reg | sink_ready) & ~eop_pending;
    assign drop        = (state_reg == FEED) & in_valid
                         & sink_valid_reg & ~sink_ready;
    assign src_beat    = (state_reg == DRAIN) & source_valid & source_ready;
    assign cur_beat    = source_sop ? '0 : beat_cnt_reg;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: start on enable, drain after the eop beat leaves,
    // then either start another frame or park in IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (enable) state_next = FEED;
            FEED:    if (xfer && sink_eop_reg) state_next = DRAIN;
            DRAIN:   if (frame_end) state_next = enable ? FEED : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output-frame tracking: position of each accepted source beat relative
    // to its sop, plus detection of every framing anomaly.
    always_comb begin
        beat_cnt_next = beat_cnt_reg;
        in_frame_next = in_frame_reg;
        frame_err_evt = 1'b0;
        frame_end     = 1'b0;
        if (src_beat) begin
            if (source_sop) begin
                if (in_frame_reg) frame_err_evt = 1'b1;
                in_frame_next = 1'b1;
                beat_cnt_next = BEAT_W'(1);
            end else if (in_frame_reg) begin
                if (beat_cnt_reg != BEAT_MAX) beat_cnt_next = beat_cnt_reg + BEAT_W'(1);
            end else begin
                frame_err_evt = 1'b1;
            end
            // An eop with no frame open has nothing to complete; it only flags.
            if (source_eop && (in_frame_reg || source_sop)) begin
                frame_end     = 1'b1;
                if (cur_beat != LAST_BEAT) frame_err_evt = 1'b1;
                in_frame_next = 1'b0;
                beat_cnt_next = '0;
            end
        end
    end

    // Sink output register and sample index: load on a free (or freeing)
    // register, empty after a transfer with nothing to replace it.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_reg        <= '0;
            sink_valid_reg <= 1'b0;
            sink_sop_reg   <= 1'b0;
            sink_eop_reg   <= 1'b0;
            sink_real_reg  <= '0;
        end else if (load) begin
            idx_reg        <= idx_reg + 1'b1;
            sink_valid_reg <= 1'b1;
            sink_sop_reg   <= (idx_reg == '0);
            sink_eop_reg   <= (idx_reg == LAST_IDX);
            sink_real_reg  <= in_data;
        end else if (xfer) begin
            sink_valid_reg <= 1'b0;
            sink_sop_reg   <= 1'b0;
            sink_eop_reg   <= 1'b0;
        end
    end

    // Source-side bookkeeping, completion pulse and frame counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt_reg    <= '0;
            in_frame_reg    <= 1'b0;
            frame_done_reg  <= 1'b0;
            frame_count_reg <= '0;
        end else begin
            beat_cnt_reg   <= beat_cnt_next;
            in_frame_reg   <= in_frame_next;
            frame_done_reg <= frame_end;
            if (frame_end) frame_count_reg <= frame_count_reg + CNT_W'(1);
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_overflow_reg <= 1'b0;
            err_frame_reg    <= 1'b0;
        end else begin
            if (drop) err_overflow_reg <= 1'b1;
            if (frame_err_evt) err_frame_reg <= 1'b1;
        end
    end

    assign sink_valid   = sink_valid_reg;
    assign sink_sop     = sink_sop_reg;
    assign sink_eop     = sink_eop_reg;
    assign sink_real    = sink_real_reg;
    assign sink_imag    = '0;
    assign sink_inverse = 1'b0;
    // The FFT source is never throttled; ready only drops while in reset.
    assign source_ready = ~reset;
    assign busy         = (state_reg != IDLE);
    assign frame_done   = frame_done_reg;
    assign frame_count  = frame_count_reg;
    assign err_overflow = err_overflow_reg;
    assign err_frame    = err_frame_reg;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer with N=8: streaming, backpressure,
// enable drop, bad output frame and reset mid-frame.
module tb_fft_frame_sequencer;

    localparam int DW = 14;
    localparam int L2 = 3;
    localparam int CW = 16;

    logic          clk;
    logic          reset;
    logic          enable;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          sink_ready;
    logic          sink_valid;
    logic          sink_sop;
    logic          sink_eop;
    logic [DW-1:0] sink_real;
    logic [DW-1:0] sink_imag;
    logic          sink_inverse;
    logic          source_valid;
    logic          source_sop;
    logic          source_eop;
    logic          source_ready;
    logic          busy;
    logic          frame_done;
    logic [CW-1:0] frame_count;
    logic          err_overflow;
    logic          err_frame;

    fft_frame_sequencer #(.DATA_W(DW), .FFT_LEN_LOG2(L2), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .in_valid(in_valid), .in_data(in_data), .sink_ready(sink_ready),
        .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
        .sink_real(sink_real), .sink_imag(sink_imag), .sink_inverse(sink_inverse),
        .source_valid(source_valid), .source_sop(source_sop), .source_eop(source_eop),
        .source_ready(source_ready), .busy(busy), .frame_done(frame_done),
        .frame_count(frame_count), .err_overflow(err_overflow), .err_frame(err_frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int done_pulses = 0;

    logic [DW-1:0] q_real[$];
    logic          q_sop[$];
    logic          q_eop[$];
    int            snap_real[64];
    logic          snap_valid[64];
    logic          snap_sop[64];
    logic          snap_eop[64];
    logic          snap_ovf[64];

    always @(negedge clk) begin
        if (frame_done) done_pulses++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Feeds ramp samples base+c each cycle until 8 sink beats transfer.
    task automatic drive_frame(input int base, input int stall_c, input int stall_n,
                               input int en_off_c);
        int c = 0;
        bit fin = 0;
        q_real.delete(); q_sop.delete(); q_eop.delete();
        while (!fin && c < 60) begin
            c++;
            @(posedge clk); #1;
            in_valid   = 1'b1;
            in_data    = DW'(base + c);
            sink_ready = !(c >= stall_c && c < stall_c + stall_n);
            if (c == en_off_c) enable = 1'b0;
            @(negedge clk);
            if (c < 64) begin
                snap_real[c]  = int'(sink_real);
                snap_valid[c] = sink_valid;
                snap_sop[c]   = sink_sop;
                snap_eop[c]   = sink_eop;
                snap_ovf[c]   = err_overflow;
            end
            if (sink_valid && sink_ready) begin
                q_real.push_back(sink_real);
                q_sop.push_back(sink_sop);
                q_eop.push_back(sink_eop);
            end
            if (q_real.size() >= 8) fin = 1;
        end
        @(posedge clk); #1;
        in_valid   = 1'b0;
        sink_ready = 1'b1;
        total++;
        if (!fin) begin
            bad++;
            $display("FAIL drive_timeout beats=%0d required=8", q_real.size());
        end
    endtask

    // Plays an output frame of len beats back from the FFT (sop first, eop last).
    task automatic src_frame(input int len);
        for (int i = 0; i < len; i++) begin
            @(posedge clk); #1;
            source_valid = 1'b1;
            source_sop   = (i == 0);
            source_eop   = (i == len - 1);
        end
        @(posedge clk); #1;
        source_valid = 1'b0;
        source_sop   = 1'b0;
        source_eop   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; in_valid = 1'b0; in_data = '0; sink_ready = 1'b1;
        source_valid = 1'b0; source_sop = 1'b0; source_eop = 1'b0;
        @(posedge clk); @(negedge clk);
        total++;
        if ({sink_valid, sink_sop, sink_eop, sink_real, sink_imag, sink_inverse,
             source_ready, busy, frame_done, frame_count, err_overflow, err_frame} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got sv=%b sr=%h rdy=%b busy=%b cnt=%0d required all 0",
                     sink_valid, sink_real, source_ready, busy, frame_count);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (source_ready !== 1'b1 || busy !== 1'b0 || frame_count !== '0) begin
            bad++;
            $display("FAIL reset_release got rdy=%b busy=%b cnt=%0d required 1 0 0",
                     source_ready, busy, frame_count);
        end
        $display("reset: rdy=%b busy=%b cnt=%0d", source_ready, busy, frame_count);
    endtask

    task automatic test_stream();
        int d0;
        enable = 1'b1;
        drive_frame(0, 99, 0, 99);
        for (int i = 0; i < 8 && i < q_real.size(); i++) begin
            total++;
            if (q_real[i] !== DW'(i + 1)) begin
                bad++;
                $display("FAIL stream_data beat=%0d got=%0d required=%0d", i, q_real[i], i + 1);
            end
            total++;
            if ({q_sop[i], q_eop[i]} !== {i == 0, i == 7}) begin
                bad++;
                $display("FAIL stream_sopeop beat=%0d got=%b%b required=%b%b",
                         i, q_sop[i], q_eop[i], i == 0, i == 7);
            end
        end
        total++;
        if (err_overflow !== 1'b0) begin
            bad++;
            $display("FAIL stream_ovf got=%b required=0", err_overflow);
        end
        d0 = done_pulses;
        src_frame(8);
        total++;
        if (done_pulses - d0 !== 1 || frame_count !== 16'd1 || busy !== 1'b1 || err_frame !== 1'b0) begin
            bad++;
            $display("FAIL stream_done got pulses=%0d cnt=%0d busy=%b errf=%b required 1 1 1 0",
                     done_pulses - d0, frame_count, busy, err_frame);
        end
        $display("stream: beats=%0d cnt=%0d", q_real.size(), frame_count);
    endtask

    task automatic test_backpressure();
        int exp_bp[8] = '{17, 18, 19, 23, 24, 25, 26, 27};
        drive_frame(16, 4, 3, 99);
        for (int i = 0; i < 8 && i < q_real.size(); i++) begin
            total++;
            if (q_real[i] !== DW'(exp_bp[i]) || {q_sop[i], q_eop[i]} !== {i == 0, i == 7}) begin
                bad++;
                $display("FAIL bp_beat beat=%0d got=%0d/%b%b required=%0d/%b%b",
                         i, q_real[i], q_sop[i], q_eop[i], exp_bp[i], i == 0, i == 7);
            end
        end
        for (int c = 4; c <= 6; c++) begin
            total++;
            if (snap_real[c] !== 19 || snap_valid[c] !== 1'b1 ||
                snap_sop[c] !== 1'b0 || snap_eop[c] !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold cycle=%0d got=%0d v=%b sop=%b eop=%b required=19 1 0 0",
                         c, snap_real[c], snap_valid[c], snap_sop[c], snap_eop[c]);
            end
        end
        total++;
        if (snap_ovf[4] !== 1'b0 || snap_ovf[5] !== 1'b1) begin
            bad++;
            $display("FAIL bp_ovf got=%b%b required=01", snap_ovf[4], snap_ovf[5]);
        end
        src_frame(8);
        total++;
        if (frame_count !== 16'd2 || err_overflow !== 1'b1) begin
            bad++;
            $display("FAIL bp_count got cnt=%0d ovf=%b required 2 1", frame_count, err_overflow);
        end
        $display("backpressure: beats=%0d cnt=%0d ovf=%b", q_real.size(), frame_count, err_overflow);
    endtask

    task automatic test_enable_drop();
        int seen = 0;
        drive_frame(32, 99, 0, 5);
        total++;
        if (q_real.size() != 8 || q_real[0] !== DW'(33) || q_real[7] !== DW'(40) || q_eop[7] !== 1'b1) begin
            bad++;
            $display("FAIL endrop_frame got beats=%0d required 8 beats 33..40 eop last", q_real.size());
        end
        src_frame(8);
        total++;
        if (busy !== 1'b0 || frame_count !== 16'd3) begin
            bad++;
            $display("FAIL endrop_idle got busy=%b cnt=%0d required 0 3", busy, frame_count);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = DW'(99);
            @(negedge clk);
            if (sink_valid || busy) seen++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL endrop_ignore got active_cycles=%0d required=0", seen);
        end
        $display("enable_drop: cnt=%0d busy=%b", frame_count, busy);
    endtask

    task automatic test_bad_frame();
        enable = 1'b1;
        drive_frame(48, 99, 0, 99);
        src_frame(6);
        total++;
        if (err_frame !== 1'b1 || frame_count !== 16'd4) begin
            bad++;
            $display("FAIL badframe got errf=%b cnt=%0d required 1 4", err_frame, frame_count);
        end
        drive_frame(56, 99, 0, 99);
        src_frame(8);
        total++;
        if (err_frame !== 1'b1 || frame_count !== 16'd5) begin
            bad++;
            $display("FAIL badframe_sticky got errf=%b cnt=%0d required 1 5", err_frame, frame_count);
        end
        $display("bad_frame: errf=%b cnt=%0d", err_frame, frame_count);
    endtask

    task automatic test_reset_mid();
        int d0;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            in_valid   = 1'b1;
            in_data    = DW'(80 + c);
            sink_ready = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        total++;
        if (source_ready !== 1'b0 || sink_valid !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_during got rdy=%b sv=%b required 0 1", source_ready, sink_valid);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({sink_valid, sink_sop, sink_eop, sink_real, busy, frame_done, frame_count,
             err_overflow, err_frame} !== '0 || source_ready !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_clear got sv=%b sr=%0d busy=%b cnt=%0d ovf=%b errf=%b rdy=%b required 0s rdy=1",
                     sink_valid, sink_real, busy, frame_count, err_overflow, err_frame, source_ready);
        end
        drive_frame(64, 99, 0, 99);
        total++;
        if (q_real.size() != 8 || q_real[0] !== DW'(65) || q_sop[0] !== 1'b1 ||
            q_real[7] !== DW'(72) || q_eop[7] !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_newframe got beats=%0d required 8 beats 65..72 sop/eop", q_real.size());
        end
        d0 = done_pulses;
        src_frame(8);
        total++;
        if (frame_count !== 16'd1 || done_pulses - d0 !== 1) begin
            bad++;
            $display("FAIL rstmid_count got cnt=%0d pulses=%0d required 1 1", frame_count, done_pulses - d0);
        end
        $display("reset_mid: cnt=%0d", frame_count);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_enable_drop();
        test_bad_frame();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
